// File: rtl/stack_move_replayer_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg
// Shared types for the move-stack replayer: direction encoding, replay FSM
// state encoding and the direction inversion mask/helper.
// No ports (package).
// -----------------------------------------------------------------------------
package move_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Flipping the MSB swaps UP<->DOWN and RIGHT<->LEFT.
    localparam logic [1:0] DIR_INVERT_MASK = 2'b10;

    function automatic dir_t dir_invert(input dir_t i_dir);
        return dir_t'(i_dir ^ DIR_INVERT_MASK);
    endfunction

endpackage

// File: rtl/stack_move_replayer_if.sv
// -----------------------------------------------------------------------------
// stack_move_replayer_if
// Groups the stack read pins and the downstream move stream.
//   stk_pop    : pop strobe to the stack
//   stk_data   : stack top word (registered by the stack)
//   stk_empty  : stack empty flag
//   move_valid : move_data holds a move
//   move_ready : consumer accepts
//   move_data  : popped (optionally inverted) move
// master = replayer side, slave = stack/consumer side.
// -----------------------------------------------------------------------------
interface stack_move_replayer_if #(
    parameter int WIDTH = 2
) ();
    logic             stk_pop;
    logic [WIDTH-1:0] stk_data;
    logic             stk_empty;
    logic             move_valid;
    logic             move_ready;
    logic [WIDTH-1:0] move_data;

    modport master (
        output stk_pop,
        input  stk_data,
        input  stk_empty,
        output move_valid,
        input  move_ready,
        output move_data
    );

    modport slave (
        input  stk_pop,
        output stk_data,
        output stk_empty,
        input  move_valid,
        output move_ready,
        input  move_data
    );
endinterface

// File: rtl/stack_move_replayer_invert.sv
// -----------------------------------------------------------------------------
// move_invert
// Combinational direction mapper used for backtracking output:
// UP<->DOWN, RIGHT<->LEFT.
//   i_dir : input direction
//   o_dir : inverted direction
// -----------------------------------------------------------------------------
module move_invert
    import move_pkg::*;
(
    input  dir_t i_dir,
    output dir_t o_dir
);
    assign o_dir = dir_invert(i_dir);
endmodule

// File: rtl/stack_move_replayer.sv
// -----------------------------------------------------------------------------
// stack_move_replayer
// On start, pops every move off the move stack (top first) and presents each
// one on a valid/ready stream. One move per POP -> WAIT -> SEND round.
// Optional feature macro: MOVE_INVERT_EN (captured moves are inverted with
// DIR_INVERT_MASK before being presented).
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous active-high reset, forces IDLE
//   i_start      : start request, honoured in IDLE only
//   i_abort      : terminate replay, IDLE next cycle
//   bus          : stack pins + move stream (master modport)
//   o_busy       : not IDLE
//   o_done       : one-cycle pulse when the stack has drained
//   o_move_count : handshakes since the last accepted start
// -----------------------------------------------------------------------------
module stack_move_replayer
    import move_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic                         i_abort,
    stack_move_replayer_if.master        bus,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_move_count
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_POP  = ST_POP;
    localparam logic [2:0] S_WAIT = ST_WAIT;
    localparam logic [2:0] S_SEND = ST_SEND;
    localparam logic [2:0] S_DONE = ST_DONE;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_stk_pop;
    logic             r_move_valid;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_move_data;
    logic [CW-1:0]    r_move_count;
    logic [WIDTH-1:0] w_move_in;
    logic             w_start_acc;
    logic             w_handshake;

    assign w_start_acc = (r_state == S_IDLE) && i_start && !i_abort;
    // abort wins over a same-cycle handshake, so it is never counted
    assign w_handshake = (r_state == S_SEND) && bus.move_ready && !i_abort;

`ifdef MOVE_INVERT_EN
    dir_t w_dir_raw;
    dir_t w_dir_inv;
    assign w_dir_raw = dir_t'(bus.stk_data);
    move_invert u_move_invert (
        .i_dir (w_dir_raw),
        .o_dir (w_dir_inv)
    );
    assign w_move_in = WIDTH'(w_dir_inv);
`else
    assign w_move_in = bus.stk_data;
`endif

    // Next-state decode; stk_empty is only looked at in IDLE and SEND.
    always_comb begin
        w_next = r_state;
        if (i_abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        w_next = bus.stk_empty ? S_DONE : S_POP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_POP:  w_next = S_WAIT;
                S_WAIT: w_next = S_SEND;
                S_SEND: begin
                    if (bus.move_ready) begin
                        w_next = bus.stk_empty ? S_DONE : S_POP;
                    end else begin
                        w_next = S_SEND;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State, registered outputs (decoded from the next state) and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_stk_pop    <= 1'b0;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_move_data  <= {WIDTH{1'b0}};
            r_move_count <= {CW{1'b0}};
        end else begin
            r_state      <= w_next;
            r_stk_pop    <= (w_next == S_POP);
            r_move_valid <= (w_next == S_SEND);
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (w_next == S_DONE);
            // stack word is valid in WAIT (one cycle after the pop)
            if ((r_state == S_WAIT) && !i_abort) begin
                r_move_data <= w_move_in;
            end
            if (w_start_acc) begin
                r_move_count <= {CW{1'b0}};
            end else if (w_handshake) begin
                r_move_count <= r_move_count + CW'(1);
            end
        end
    end

    assign bus.stk_pop    = r_stk_pop;
    assign bus.move_valid = r_move_valid;
    assign bus.move_data  = r_move_data;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_move_count   = r_move_count;

endmodule
